// File: rtl/alu_pkg.sv
// Shared ALU op/flag types plus branch-resolve controller types.
// Used by alu_branch and branch_resolve_ctrl.
package alu_pkg;

  // Storage width of the captured request bundle.
  // Instances use WIDTH <= XLEN and TAG_W <= BRC_TAG_W.
  localparam int XLEN      = 64;
  localparam int BRC_TAG_W = 4;

  typedef enum logic [3:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_XOR,
    ALU_SLL,
    ALU_SRL,
    ALU_SRA,
    ALU_SLT,
    ALU_SLTU,
    ALU_BEQ,
    ALU_BNE,
    ALU_BLT,
    ALU_BGE,
    ALU_BLTU,
    ALU_BGEU
  } alu_op_t;

  typedef struct packed {
    logic invalid_op;
    logic taken;
  } alu_flags_t;

  typedef enum logic [1:0] {
    IDLE,
    EVAL,
    DONE,
    REDIR
  } brc_state_t;

  typedef struct packed {
    alu_op_t                op;
    logic [XLEN-1:0]        rs1;
    logic [XLEN-1:0]        rs2;
    logic [XLEN-1:0]        pc;
    logic [XLEN-1:0]        imm;
    logic                   pred_taken;
    logic [XLEN-1:0]        pred_target;
    logic [BRC_TAG_W-1:0]   tag;
  } brc_req_t;

endpackage

// File: rtl/alu_branch.sv
// Branch condition comparator shared with the ALU.
// Non-branch ops report invalid_op and never taken.
module alu_branch
  import alu_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  alu_op_t          i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output alu_flags_t       o_flags
);

  logic w_eq;
  logic w_lt;
  logic w_ltu;

  assign w_eq  = (i_a == i_b);
  assign w_lt  = ($signed(i_a) < $signed(i_b));
  assign w_ltu = (i_a < i_b);

  // Decode the branch condition for the requested op.
  always_comb begin
    o_flags = '0;
    unique case (1'b1)
      (i_op == ALU_BEQ):  o_flags.taken = w_eq;
      (i_op == ALU_BNE):  o_flags.taken = ~w_eq;
      (i_op == ALU_BLT):  o_flags.taken = w_lt;
      (i_op == ALU_BGE):  o_flags.taken = ~w_lt;
      (i_op == ALU_BLTU): o_flags.taken = w_ltu;
      (i_op == ALU_BGEU): o_flags.taken = ~w_ltu;
      default:            o_flags.invalid_op = 1'b1;
    endcase
  end

endmodule

// File: rtl/branch_resolve_ctrl.sv
// Execute-stage branch resolution: one uop in flight, held fetch redirect.
// Optional perf counters enabled by defining BRANCH_PERF_CNT_EN.
module branch_resolve_ctrl
  import alu_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int TAG_W = 4,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             req_valid,
  output logic             req_ready,
  input  alu_op_t          req_op,
  input  logic [WIDTH-1:0] req_rs1,
  input  logic [WIDTH-1:0] req_rs2,
  input  logic [WIDTH-1:0] req_pc,
  input  logic [WIDTH-1:0] req_imm,
  input  logic             req_pred_taken,
  input  logic [WIDTH-1:0] req_pred_target,
  input  logic [TAG_W-1:0] req_tag,
  output logic             resp_valid,
  output logic             resp_taken,
  output logic             resp_mispredict,
  output logic             resp_exc,
  output logic [TAG_W-1:0] resp_tag,
  output logic             redir_valid,
  input  logic             redir_ready,
  output logic [WIDTH-1:0] redir_pc,
  output logic [CNT_W-1:0] perf_branches,
  output logic [CNT_W-1:0] perf_mispredicts
);

  brc_state_t       r_state;
  brc_req_t         r_req;
  logic             r_taken;
  logic             r_mis;
  logic             r_exc;
  logic [WIDTH-1:0] r_redir_pc;

  alu_flags_t       w_flags;
  logic [WIDTH-1:0] w_pc;
  logic [WIDTH-1:0] w_tgt;
  logic [WIDTH-1:0] w_seq;
  logic [WIDTH-1:0] w_npc;
  logic             w_taken;
  logic             w_exc;
  logic             w_mis;
  logic             w_accept;
  logic             w_resp;
  logic             w_redir;
  logic             w_redir_done;

  alu_branch #(
    .WIDTH (WIDTH)
  ) u_cmp (
    .i_op    (r_req.op),
    .i_a     (r_req.rs1[WIDTH-1:0]),
    .i_b     (r_req.rs2[WIDTH-1:0]),
    .o_flags (w_flags)
  );

  assign w_pc    = r_req.pc[WIDTH-1:0];
  assign w_tgt   = w_pc + r_req.imm[WIDTH-1:0];
  assign w_seq   = w_pc + WIDTH'(4);
  assign w_taken = w_flags.taken & ~w_flags.invalid_op;
  assign w_exc   = w_flags.invalid_op
                 | (w_taken & (w_tgt[1:0] != 2'b00));
  // Exceptions go to the trap unit, so they never redirect fetch.
  assign w_mis   = ~w_exc
                 & ((w_taken != r_req.pred_taken)
                 | (w_taken
                 & (w_tgt != r_req.pred_target[WIDTH-1:0])));
  assign w_npc   = w_taken ? w_tgt : w_seq;

  assign w_accept     = req_valid & req_ready;
  assign w_resp       = (r_state == DONE) & ~flush;
  assign w_redir      = (((r_state == DONE) & r_mis)
                      | (r_state == REDIR)) & ~flush;
  assign w_redir_done = w_redir & redir_ready;

  assign req_ready       = (r_state == IDLE) & ~flush & ~rst;
  assign resp_valid      = w_resp;
  assign resp_taken      = r_taken;
  assign resp_mispredict = r_mis;
  assign resp_exc        = r_exc;
  assign resp_tag        = r_req.tag[TAG_W-1:0];
  assign redir_valid     = w_redir;
  assign redir_pc        = r_redir_pc;

  // Control FSM; flush returns to IDLE from any state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else if (flush) begin
      r_state <= IDLE;
    end else begin
      unique case (r_state)
        IDLE:    if (w_accept) r_state <= EVAL;
        EVAL:    r_state <= DONE;
        DONE:    r_state <= (r_mis & ~redir_ready)
                          ? REDIR : IDLE;
        REDIR:   if (redir_ready) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // Capture the request bundle at the accept edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_req <= '0;
    end else if (w_accept) begin
      r_req.op          <= req_op;
      r_req.rs1         <= XLEN'(req_rs1);
      r_req.rs2         <= XLEN'(req_rs2);
      r_req.pc          <= XLEN'(req_pc);
      r_req.imm         <= XLEN'(req_imm);
      r_req.pred_taken  <= req_pred_taken;
      r_req.pred_target <= XLEN'(req_pred_target);
      r_req.tag         <= BRC_TAG_W'(req_tag);
    end
  end

  // Register the outcome at the edge leaving EVAL.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_taken    <= 1'b0;
      r_mis      <= 1'b0;
      r_exc      <= 1'b0;
      r_redir_pc <= '0;
    end else if (r_state == EVAL) begin
      r_taken    <= w_taken;
      r_mis      <= w_mis;
      r_exc      <= w_exc;
      r_redir_pc <= w_npc;
    end
  end

`ifdef BRANCH_PERF_CNT_EN
  logic [CNT_W-1:0] r_perf_br;
  logic [CNT_W-1:0] r_perf_mis;

  // Saturating event counters; only reset clears them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_perf_br  <= '0;
      r_perf_mis <= '0;
    end else begin
      if (w_resp && !(&r_perf_br))
        r_perf_br <= r_perf_br + CNT_W'(1);
      if (w_redir_done && !(&r_perf_mis))
        r_perf_mis <= r_perf_mis + CNT_W'(1);
    end
  end

  assign perf_branches    = r_perf_br;
  assign perf_mispredicts = r_perf_mis;
`else
  logic w_unused;
  assign w_unused         = w_redir_done;
  assign perf_branches    = '0;
  assign perf_mispredicts = '0;
`endif

endmodule
